// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_PIPE_FLAGS_EN to add the pipelined ovf and zero result flags.
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_PIPE_FLAGS_EN
  output logic             ovf,
  output logic             zero,
`endif
  output logic             cout
);

  localparam int unsigned NG = WIDTH / GROUP;
`ifdef CLA_PIPE_FLAGS_EN
  localparam int unsigned RW = WIDTH + 3;
`else
  localparam int unsigned RW = WIDTH + 1;
`endif

  // Operand conditioning: subtraction is A + ~B + 1, borrow-in flips the carry.
  logic [WIDTH-1:0] b_e;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;

  assign b_e   = b ^ {WIDTH{sub}};
  assign c0_in = cin ^ sub;
  assign p_in  = a ^ b_e;
  assign g_in  = a & b_e;

  // Lookahead core inputs, sourced from the operands or the stage-1 register.
  logic [WIDTH-1:0] cp;
  logic [WIDTH-1:0] cg;
  logic             cc0;

  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;
  logic [WIDTH:0]   c;

  always_comb begin : lookahead
    logic term;
    gp   = '0;
    gg   = '0;
    gc   = '0;
    c    = '0;
    term = 1'b0;

    // First level: group propagate and generate.
    for (int j = 0; j < int'(NG); j++) begin
      gp[j] = &cp[j*GROUP +: GROUP];
      for (int i = 0; i < int'(GROUP); i++) begin
        term = cg[j*GROUP + i];
        for (int k = i + 1; k < int'(GROUP); k++) begin
          term = term & cp[j*GROUP + k];
        end
        gg[j] = gg[j] | term;
      end
    end

    // Second level: every group carry is a flat sum of products, no inter-group ripple.
    gc[0] = cc0;
    for (int j = 0; j < int'(NG); j++) begin
      term = cc0;
      for (int k = 0; k <= j; k++) begin
        term = term & gp[k];
      end
      gc[j+1] = term;
      for (int m = 0; m <= j; m++) begin
        term = gg[m];
        for (int k = m + 1; k <= j; k++) begin
          term = term & gp[k];
        end
        gc[j+1] = gc[j+1] | term;
      end
    end

    // Bit carries inside each group, looked ahead from the group carry-in.
    for (int j = 0; j < int'(NG); j++) begin
      for (int i = 0; i < int'(GROUP); i++) begin
        term = gc[j];
        for (int k = 0; k < i; k++) begin
          term = term & cp[j*GROUP + k];
        end
        c[j*GROUP + i] = term;
        for (int m = 0; m < i; m++) begin
          term = cg[j*GROUP + m];
          for (int k = m + 1; k < i; k++) begin
            term = term & cp[j*GROUP + k];
          end
          c[j*GROUP + i] = c[j*GROUP + i] | term;
        end
      end
    end
    c[WIDTH] = gc[NG];
  end

  logic [WIDTH-1:0] sum_c;
  logic [RW-1:0]    res;

  assign sum_c = cp ^ c[WIDTH-1:0];
`ifdef CLA_PIPE_FLAGS_EN
  assign res = {~|sum_c, c[WIDTH-1] ^ c[WIDTH], c[WIDTH], sum_c};
`else
  assign res = {c[WIDTH], sum_c};
`endif

  // Elastic control: acc[k] means stage k may load this cycle; acc[STAGES] is downstream.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES:0]   acc;

  always_comb begin
    acc         = '0;
    acc[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc[k] = !v_q[k] || acc[k+1];
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      v_in[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (acc[k]) begin
          v_q[k] <= v_in[k];
        end
      end
    end
  end

  assign in_ready  = acc[0];
  assign out_valid = v_q[STAGES-1];

  logic [RW-1:0] out_q;

  if (STAGES == 1) begin : g_one
    logic [RW-1:0] r0_q;

    assign cp  = p_in;
    assign cg  = g_in;
    assign cc0 = c0_in;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r0_q <= '0;
      end else if (acc[0] && in_valid) begin
        r0_q <= res;
      end
    end

    assign out_q = r0_q;
  end else begin : g_multi
    logic [2*WIDTH:0] pg_q;
    logic [RW-1:0]    r1_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pg_q <= '0;
      end else if (acc[0] && in_valid) begin
        pg_q <= {c0_in, g_in, p_in};
      end
    end

    assign cp  = pg_q[WIDTH-1:0];
    assign cg  = pg_q[2*WIDTH-1:WIDTH];
    assign cc0 = pg_q[2*WIDTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r1_q <= '0;
      end else if (acc[1] && v_q[0]) begin
        r1_q <= res;
      end
    end

    if (STAGES == 3) begin : g_three
      logic [RW-1:0] r2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r2_q <= '0;
        end else if (acc[2] && v_q[1]) begin
          r2_q <= r1_q;
        end
      end

      assign out_q = r2_q;
    end else begin : g_two
      assign out_q = r1_q;
    end
  end

  assign sum  = out_q[WIDTH-1:0];
  assign cout = out_q[WIDTH];
`ifdef CLA_PIPE_FLAGS_EN
  assign ovf  = out_q[WIDTH+1];
  assign zero = out_q[WIDTH+2];
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: default 16-bit pipe plus 32-bit STAGES=1/3 instances.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit, GROUP=4, STAGES=2
  logic        iv, ir, ov, ordy, cin, sub, cout;
  logic [15:0] a, b, sum;
  // 32-bit, GROUP=8, STAGES=1 and STAGES=3 share inputs
  logic        iv32, or32, cin32, sub32, ir1, ov1, cout1, ir3, ov3, cout3;
  logic [31:0] a32, b32, sum1, sum3;
`ifdef CLA_PIPE_FLAGS_EN
  logic        ovf, zero, ovf1, zero1, ovf3, zero3;
`endif

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov), .out_ready(ordy), .sum(sum),
`ifdef CLA_PIPE_FLAGS_EN
    .ovf(ovf), .zero(zero),
`endif
    .cout(cout)
  );

  cla_pipe_adder #(.WIDTH(32), .GROUP(8), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir1), .a(a32), .b(b32), .cin(cin32),
    .sub(sub32), .out_valid(ov1), .out_ready(or32), .sum(sum1),
`ifdef CLA_PIPE_FLAGS_EN
    .ovf(ovf1), .zero(zero1),
`endif
    .cout(cout1)
  );

  cla_pipe_adder #(.WIDTH(32), .GROUP(8), .STAGES(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir3), .a(a32), .b(b32), .cin(cin32),
    .sub(sub32), .out_valid(ov3), .out_ready(or32), .sum(sum3),
`ifdef CLA_PIPE_FLAGS_EN
    .ovf(ovf3), .zero(zero3),
`endif
    .cout(cout3)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [18:0] sbq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {zero, ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] ye;
    logic [16:0] t;
    logic        v;
    ye = sb ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + {16'd0, ci ^ sb};
    v  = (x[15] == ye[15]) && (t[15] != x[15]);
    return {t[15:0] == 16'd0, v, t[16], t[15:0]};
  endfunction

  // Handshakes are sampled mid-cycle; they describe the transfers of the next rising edge.
  always @(negedge clk) begin : mon
    logic [18:0] e;
    if (!rst) begin
      if (iv && ir) sbq.push_back(model(a, b, cin, sub));
      if (ov && ordy) begin
        if (sbq.size() == 0) begin
          check("spurious_out", ov, 1'b0);
        end else begin
          e = sbq.pop_front();
          check("sb_sum", sum, e[15:0]);
          check("sb_cout", cout, e[16]);
`ifdef CLA_PIPE_FLAGS_EN
          check("sb_ovf", ovf, e[17]);
          check("sb_zero", zero, e[18]);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int   nacc;
    logic pend;
    iv = 0; ordy = 1; a = '0; b = '0; cin = 0; sub = 0;
    iv32 = 0; or32 = 1; a32 = '0; b32 = '0; cin32 = 0; sub32 = 0;

    #2;
    check("rst_in_ready", ir, 1'b1);
    check("rst_out_valid", ov, 1'b0);
    check("rst_sum", sum, 16'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_out_valid_s3", ov3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 0;
    #1 check("post_rst_in_ready", ir, 1'b1);
    step();

    // Carry wrap and two-cycle latency
    a = 16'hFFFF; b = 16'h0001; iv = 1;
    step();
    iv = 0;
    check("lat_edge1_valid", ov, 1'b0);
    step();
    check("lat_edge2_valid", ov, 1'b1);
    check("wrap_sum", sum, 16'h0000);
    check("wrap_cout", cout, 1'b1);
`ifdef CLA_PIPE_FLAGS_EN
    check("wrap_zero", zero, 1'b1);
    check("wrap_ovf", ovf, 1'b0);
`endif
    step();

    // Subtraction, back-to-back
    a = 16'h8000; b = 16'h0001; sub = 1; cin = 0; iv = 1;
    step();
    a = 16'h0003; b = 16'h0005;
    step();
    iv = 0; sub = 0;
    check("sub1_sum", sum, 16'h7FFF);
    check("sub1_cout", cout, 1'b1);
`ifdef CLA_PIPE_FLAGS_EN
    check("sub1_ovf", ovf, 1'b1);
`endif
    step();
    check("sub2_sum", sum, 16'hFFFE);
    check("sub2_cout", cout, 1'b0);
`ifdef CLA_PIPE_FLAGS_EN
    check("sub2_ovf", ovf, 1'b0);
`endif
    step();

    // Backpressure: offer four beats into a stalled pipe
    ordy = 0; nacc = 0; iv = 1; cin = 1;
    for (int i = 0; i < 4; i++) begin
      a = 16'h1000 * 16'(nacc + 1) + 16'(nacc);
      b = 16'h0101;
      #1 if (ir) nacc++;
      step();
    end
    check("bp_accepted", nacc, 2);
    check("bp_in_ready", ir, 1'b0);
    check("bp_out_valid", ov, 1'b1);
    check("bp_hold_a", sum, sbq[0][15:0]);
    step();
    check("bp_hold_b", sum, sbq[0][15:0]);
    ordy = 1;
    #1 check("bp_pass_through", ir, 1'b1);
    step();
    check("bp_swap_full", ov, 1'b1);
    a = 16'h4003; b = 16'h0101;
    step();
    iv = 0; cin = 0;
    drain();

    // Reset with two beats in flight
    ordy = 0; iv = 1; a = 16'h1234; b = 16'h1111;
    step();
    a = 16'h2222; b = 16'h3333;
    step();
    iv = 0;
    check("pre_rst_out_valid", ov, 1'b1);
    #1 rst = 1;
    #1 check("rst_async_out_valid", ov, 1'b0);
    check("rst_async_in_ready", ir, 1'b1);
    sbq.delete();
    ordy = 1;
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_quiet", ov, 1'b0);
    end

    // Streaming with random backpressure
    nacc = 0; pend = 0;
    for (int cyc = 0; cyc < 5000 && nacc < 1000; cyc++) begin
      if (!pend) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        iv = 1; pend = 1;
      end
      ordy = 1'($urandom_range(0, 1));
      #1 if (ir) begin
        nacc++;
        pend = 0;
      end
      step();
    end
    iv = 0; ordy = 1;
    check("stream_count", nacc, 1000);
    drain();

    // 32-bit sweep: STAGES=1 and STAGES=3 latency and wrap
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; iv32 = 1;
    #1 check("s1_in_ready", ir1, 1'b1);
    step();
    iv32 = 0;
    check("s1_lat_valid", ov1, 1'b1);
    check("s1_wrap_sum", sum1, 32'h0);
    check("s1_wrap_cout", cout1, 1'b1);
    check("s3_lat1_valid", ov3, 1'b0);
    step();
    check("s3_lat2_valid", ov3, 1'b0);
    step();
    check("s3_lat3_valid", ov3, 1'b1);
    check("s3_wrap_sum", sum3, 32'h0);
    check("s3_wrap_cout", cout3, 1'b1);
    a32 = 32'd5; b32 = 32'd7; sub32 = 1; iv32 = 1;
    step();
    iv32 = 0; sub32 = 0;
    check("s1_sub_sum", sum1, 32'hFFFF_FFFE);
    check("s1_sub_cout", cout1, 1'b0);
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
